// File: rtl/fetch_sequencer_if.sv
// Control bundle between the fetch sequencer and the datapath/memory.
// master = sequencer side, slave = datapath/memory/execute side.
`timescale 1ns/1ps
interface fetch_sequencer_if;
  logic        run;
  logic        MFC;
  logic        exec_done;
  logic        MARE, MDRE, IRE, PCE, nPCE;
  logic        ClrPC, nPCClr, IRClr;
  logic [1:0]  MAR_SEL, MDR_SEL, nPC_SEL;
  logic        MOP_SEL;
  logic [5:0]  OP1;
  logic        nPC_ADDSEL;
  logic        MFA;
  logic        nPC_ADD;
  logic        ir_valid;
  logic        mem_fault;
  logic [3:0]  state;
  logic [15:0] fetch_count;

  modport master (
    input  run, MFC, exec_done,
    output MARE, MDRE, IRE, PCE, nPCE, ClrPC, nPCClr, IRClr,
           MAR_SEL, MDR_SEL, nPC_SEL, MOP_SEL, OP1, nPC_ADDSEL,
           MFA, nPC_ADD, ir_valid, mem_fault, state, fetch_count
  );

  modport slave (
    output run, MFC, exec_done,
    input  MARE, MDRE, IRE, PCE, nPCE, ClrPC, nPCClr, IRClr,
           MAR_SEL, MDR_SEL, nPC_SEL, MOP_SEL, OP1, nPC_ADDSEL,
           MFA, nPC_ADD, ir_valid, mem_fault, state, fetch_count
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Moore FSM sequencing datapath reset and instruction fetch; MFA/MFC memory handshake with timeout.
// Latency: 3+k edges F_MAR->ir_valid (k = MFA cycles); stalls in F_MEM for MFC and in EXEC for exec_done.
`timescale 1ns/1ps
module fetch_sequencer #(
  parameter int          MFC_TIMEOUT = 16,
  parameter logic [5:0]  RD_WORD_OP  = 6'h08
) (
  input  logic               Clk,
  input  logic               Clr,
  fetch_sequencer_if.master  bus
);

  typedef enum logic [3:0] {
    RST_CLR = 4'd0,
    RST_INC = 4'd1,
    IDLE    = 4'd2,
    F_MAR   = 4'd3,
    F_MEM   = 4'd4,
    F_IR    = 4'd5,
    F_PC    = 4'd6,
    EXEC    = 4'd7,
    FAULT   = 4'd8
  } state_e;

  localparam logic [7:0] TMO_LAST = 8'(MFC_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [7:0]  tmo_q, tmo_d;
  logic [15:0] cnt_q, cnt_d;

  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      state_q <= RST_CLR;
      tmo_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    tmo_d           = tmo_q;
    cnt_d           = cnt_q;

    bus.MARE        = 1'b1;
    bus.MDRE        = 1'b1;
    bus.IRE         = 1'b1;
    bus.PCE         = 1'b1;
    bus.nPCE        = 1'b1;
    bus.ClrPC       = 1'b1;
    bus.nPCClr      = 1'b1;
    bus.IRClr       = 1'b1;
    bus.MAR_SEL     = 2'd1;
    bus.MDR_SEL     = 2'd0;
    bus.nPC_SEL     = 2'd0;
    bus.MOP_SEL     = 1'b1;
    bus.OP1         = RD_WORD_OP;
    bus.nPC_ADDSEL  = 1'b0;
    bus.MFA         = 1'b0;
    bus.nPC_ADD     = 1'b0;
    bus.ir_valid    = 1'b0;
    bus.mem_fault   = 1'b0;
    bus.state       = state_q;
    bus.fetch_count = cnt_q;

    case (state_q)
      RST_CLR: begin
        bus.ClrPC  = 1'b0;
        bus.nPCClr = 1'b0;
        bus.IRClr  = 1'b0;
        state_d    = RST_INC;
      end
      RST_INC: begin
        bus.nPCE    = 1'b0;
        bus.nPC_ADD = 1'b1;
        state_d     = IDLE;
      end
      IDLE: begin
        if (bus.run) state_d = F_MAR;
      end
      F_MAR: begin
        bus.MARE = 1'b0;
        tmo_d    = '0;
        state_d  = F_MEM;
      end
      F_MEM: begin
        bus.MFA  = 1'b1;
        bus.MDRE = 1'b0;
        // A late MFC on the final allowed cycle still wins over the timeout.
        if (bus.MFC)                 state_d = F_IR;
        else if (tmo_q == TMO_LAST)  state_d = FAULT;
        else                         tmo_d   = tmo_q + 8'd1;
      end
      F_IR: begin
        bus.IRE = 1'b0;
        state_d = F_PC;
      end
      F_PC: begin
        bus.PCE     = 1'b0;
        bus.nPCE    = 1'b0;
        bus.nPC_ADD = 1'b1;
        cnt_d       = cnt_q + 16'd1;
        state_d     = EXEC;
      end
      EXEC: begin
        bus.ir_valid = 1'b1;
        if (bus.exec_done) state_d = bus.run ? F_MAR : IDLE;
      end
      FAULT: begin
        bus.mem_fault = 1'b1;
      end
      default: begin
        state_d = RST_CLR;
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: cycle vector table, directed corners, randomized fetches vs. transaction model.
`timescale 1ns/1ps
module tb_fetch_sequencer;
  localparam int TMO = 16;

  logic clk;
  logic clr;
  int   tests;
  int   failed;

  fetch_sequencer_if bus();

  fetch_sequencer #(.MFC_TIMEOUT(TMO), .RD_WORD_OP(6'h08)) dut (
    .Clk (clk),
    .Clr (clr),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Datapath and RAM driven by the control outputs.
  logic [31:0] pc, npc, mar, mdr, ir;

  function automatic logic [31:0] ram_word(input logic [31:0] a);
    return (a * 32'h0100_0193) ^ 32'hC0DE_0000;
  endfunction

  always @(posedge clk) begin
    if (!bus.ClrPC) pc <= 32'd0;
    else if (!bus.PCE) pc <= npc;
    if (!bus.nPCClr) npc <= 32'd0;
    else if (!bus.nPCE) npc <= bus.nPC_ADD ? npc + 32'd4 : npc;
    if (!bus.IRClr) ir <= 32'd0;
    else if (!bus.IRE) ir <= mdr;
    if (!bus.MARE) mar <= pc;
    if (!bus.MDRE) mdr <= ram_word(mar);
  end

  // Transaction model: next fetch address and completed fetches since reset.
  logic [31:0] exp_addr;
  logic [15:0] exp_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_mar(input string tag);
    int tw;
    tw = 0;
    while (bus.MARE !== 1'b0 && tw < 8) begin
      tick();
      tw++;
    end
    check({tag, "_mar_start"}, {31'd0, bus.MARE}, 32'd0);
  endtask

  task automatic fetch_one(input int k, input int d, input bit drop, input bit run_after);
    int t, mfa_n, mdre_bad;
    bus.run = 1'b1;
    wait_mar("fetch");
    t = 0; mfa_n = 0; mdre_bad = 0;
    while (bus.ir_valid !== 1'b1 && t < k + 12) begin
      tick();
      t++;
      if (bus.MFA === 1'b1) begin
        mfa_n++;
        if (bus.MDRE !== 1'b0) mdre_bad++;
        if (drop) bus.run = 1'b0;
      end
      bus.MFC = (bus.MFA === 1'b1) && (mfa_n == k);
    end
    bus.MFC = 1'b0;
    check("latency",   t, 3 + k);
    check("mfa_cycles", mfa_n, k);
    check("mdre_low",  mdre_bad, 0);
    check("no_fault",  {31'd0, bus.mem_fault}, 32'd0);
    check("ir_word",   ir, ram_word(exp_addr));
    check("pc_step",   pc, exp_addr + 32'd4);
    check("npc_step",  npc, exp_addr + 32'd8);
    exp_addr = exp_addr + 32'd4;
    exp_cnt  = exp_cnt + 16'd1;
    check("fetch_count", {16'd0, bus.fetch_count}, {16'd0, exp_cnt});
    repeat (d) tick();
    check("ir_valid_hold", {31'd0, bus.ir_valid}, 32'd1);
    bus.exec_done = 1'b1;
    bus.run = run_after;
    tick();
    bus.exec_done = 1'b0;
    check("after_exec", {27'd0, bus.state, bus.ir_valid}, {27'd0, (run_after ? 4'd3 : 4'd2), 1'b0});
  endtask

  typedef struct packed {
    logic       run, mfc, exd;
    logic [3:0] st;
    logic [4:0] en;
    logic [2:0] clr;
    logic       mfa, add, irv;
  } vec_t;

  vec_t vecs[16];

  initial begin
    tests = 0;
    failed = 0;
    clr = 1'b0;
    bus.run = 1'b0;
    bus.MFC = 1'b0;
    bus.exec_done = 1'b0;

    //          run  mfc  exd  state  {MARE,MDRE,IRE,PCE,nPCE} clears  mfa  add  irv
    vecs[0]  = {1'b0,1'b0,1'b0,4'd1,5'b11110,3'b111,1'b0,1'b1,1'b0};
    vecs[1]  = {1'b0,1'b0,1'b0,4'd2,5'b11111,3'b111,1'b0,1'b0,1'b0};
    vecs[2]  = {1'b0,1'b0,1'b0,4'd2,5'b11111,3'b111,1'b0,1'b0,1'b0};
    vecs[3]  = {1'b1,1'b0,1'b0,4'd3,5'b01111,3'b111,1'b0,1'b0,1'b0};
    vecs[4]  = {1'b1,1'b0,1'b0,4'd4,5'b10111,3'b111,1'b1,1'b0,1'b0};
    vecs[5]  = {1'b0,1'b1,1'b0,4'd5,5'b11011,3'b111,1'b0,1'b0,1'b0};
    vecs[6]  = {1'b0,1'b0,1'b1,4'd6,5'b11100,3'b111,1'b0,1'b1,1'b0};
    vecs[7]  = {1'b0,1'b0,1'b0,4'd7,5'b11111,3'b111,1'b0,1'b0,1'b1};
    vecs[8]  = {1'b1,1'b0,1'b0,4'd7,5'b11111,3'b111,1'b0,1'b0,1'b1};
    vecs[9]  = {1'b1,1'b0,1'b1,4'd3,5'b01111,3'b111,1'b0,1'b0,1'b0};
    vecs[10] = {1'b1,1'b1,1'b0,4'd4,5'b10111,3'b111,1'b1,1'b0,1'b0};
    vecs[11] = {1'b1,1'b1,1'b0,4'd5,5'b11011,3'b111,1'b0,1'b0,1'b0};
    vecs[12] = {1'b1,1'b0,1'b0,4'd6,5'b11100,3'b111,1'b0,1'b1,1'b0};
    vecs[13] = {1'b1,1'b0,1'b0,4'd7,5'b11111,3'b111,1'b0,1'b0,1'b1};
    vecs[14] = {1'b0,1'b0,1'b1,4'd2,5'b11111,3'b111,1'b0,1'b0,1'b0};
    vecs[15] = {1'b0,1'b0,1'b0,4'd2,5'b11111,3'b111,1'b0,1'b0,1'b0};

    repeat (3) tick();
    check("rst_state", {28'd0, bus.state}, 32'd0);
    check("rst_clears", {29'd0, bus.ClrPC, bus.nPCClr, bus.IRClr}, 32'd0);
    check("rst_misc", {bus.MARE, bus.MDRE, bus.IRE, bus.PCE, bus.nPCE, bus.MFA, bus.mem_fault,
                       bus.ir_valid, bus.fetch_count}, {5'b11111, 3'b000, 16'd0});
    check("const_sel", {bus.MAR_SEL, bus.MDR_SEL, bus.nPC_SEL, bus.MOP_SEL, bus.OP1, bus.nPC_ADDSEL},
          {2'd1, 2'd0, 2'd0, 1'b1, 6'h08, 1'b0});

    clr = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.run = vecs[i].run;
      bus.MFC = vecs[i].mfc;
      bus.exec_done = vecs[i].exd;
      tick();
      check($sformatf("vec%0d", i),
            {14'd0, bus.state, bus.MARE, bus.MDRE, bus.IRE, bus.PCE, bus.nPCE,
             bus.ClrPC, bus.nPCClr, bus.IRClr, bus.MFA, bus.nPC_ADD, bus.ir_valid},
            {14'd0, vecs[i].st, vecs[i].en, vecs[i].clr, vecs[i].mfa, vecs[i].add, vecs[i].irv});
      if (i == 1) check("idle_pc_npc", {pc[15:0], npc[15:0]}, {16'd0, 16'd4});
    end
    bus.MFC = 1'b0;
    bus.exec_done = 1'b0;
    check("tbl_pc", pc, 32'd8);
    check("tbl_npc", npc, 32'd12);
    check("tbl_ir", ir, ram_word(32'd4));
    check("tbl_count", {16'd0, bus.fetch_count}, 32'd2);
    exp_addr = 32'd8;
    exp_cnt  = 16'd2;

    fetch_one(5, 2, 1'b0, 1'b1);
    fetch_one(TMO, 0, 1'b0, 1'b1);
    fetch_one(1, 1, 1'b1, 1'b0);

    for (int n = 0; n < 25; n++) begin
      fetch_one(int'($urandom_range(1, TMO)), int'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // MFC never arrives: fault after exactly TMO MFA cycles, sticky until Clr.
    begin
      int t, mfa_n;
      bus.run = 1'b1;
      wait_mar("fault");
      t = 0; mfa_n = 0;
      while (t < 3 * TMO) begin
        tick();
        t++;
        if (bus.MFA === 1'b1) mfa_n++;
        else if (mfa_n > 0) break;
      end
      check("fault_mfa_cycles", mfa_n, TMO);
      check("fault_state", {27'd0, bus.state, bus.mem_fault}, {27'd0, 4'd8, 1'b1});
      check("fault_mfa_low", {31'd0, bus.MFA}, 32'd0);
      for (int j = 0; j < 6; j++) begin
        bus.run = 1'($urandom_range(0, 1));
        bus.MFC = 1'($urandom_range(0, 1));
        bus.exec_done = 1'($urandom_range(0, 1));
        tick();
      end
      bus.MFC = 1'b0;
      bus.exec_done = 1'b0;
      check("fault_sticky", {27'd0, bus.state, bus.mem_fault}, {27'd0, 4'd8, 1'b1});
      clr = 1'b0;
      #1;
      check("fault_clr", {11'd0, bus.mem_fault, bus.state, bus.fetch_count}, 32'd0);
      tick();
      tick();
      clr = 1'b1;
      exp_addr = 32'd0;
      exp_cnt = 16'd0;
    end

    fetch_one(2, 0, 1'b0, 1'b0);

    // Clr asserted between edges while MFA is high.
    bus.run = 1'b1;
    wait_mar("midclr");
    tick();
    check("midclr_mfa_hi", {31'd0, bus.MFA}, 32'd1);
    tick();
    #2;
    clr = 1'b0;
    #1;
    check("midclr_async", {11'd0, bus.MFA, bus.state, bus.fetch_count}, 32'd0);
    tick();
    tick();
    clr = 1'b1;
    exp_addr = 32'd0;
    exp_cnt = 16'd0;
    fetch_one(3, 0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
